// File: rtl/gcode_parser.sv
// gcode_parser: streaming G-code line parser with modal X/Y and a set_ready/controller_ready
// handshake. Define GCODE_COMMENT_EN to accept ';' line comments and '(...)' inline comments.
module gcode_parser (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        set_ready,
    input  logic        controller_ready,
    output logic [4:0]  cmd,
    output logic [13:0] x_value,
    output logic [13:0] y_value,
    output logic        parse_error
);

`ifdef GCODE_COMMENT_EN
    localparam bit CommentEn = 1'b1;
`else
    localparam bit CommentEn = 1'b0;
`endif

    localparam logic [7:0] ChLf   = 8'h0a;
    localparam logic [7:0] ChCr   = 8'h0d;
    localparam logic [7:0] ChSp   = 8'h20;
    localparam logic [7:0] ChSemi = 8'h3b;
    localparam logic [7:0] ChLpar = 8'h28;
    localparam logic [7:0] ChRpar = 8'h29;
    localparam logic [7:0] ChZero = 8'h30;
    localparam logic [7:0] ChNine = 8'h39;
    localparam logic [7:0] ChG    = 8'h47;
    localparam logic [7:0] ChM    = 8'h4d;
    localparam logic [7:0] ChX    = 8'h58;
    localparam logic [7:0] ChY    = 8'h59;
    localparam logic [13:0] AccMax = 14'd16383;

    typedef enum logic [2:0] {
        StWord,
        StNum,
        StSkip,
        StIssue,
        StComment,
        StParen
    } state_e;

    typedef enum logic [1:0] {
        FldG,
        FldM,
        FldX,
        FldY
    } field_e;

    state_e      state_q, state_d;
    field_e      field_q, field_d;
    logic [13:0] acc_q, acc_d;
    logic        digit_q, digit_d;
    logic        gm_q, gm_d;
    logic        is_m_q, is_m_d;
    logic [3:0]  code_q, code_d;
    logic        x_seen_q, x_seen_d;
    logic [13:0] x_line_q, x_line_d;
    logic        y_seen_q, y_seen_d;
    logic [13:0] y_line_q, y_line_d;
    logic [4:0]  cmd_q, cmd_d;
    logic [13:0] x_q, x_d;
    logic [13:0] y_q, y_d;
    logic        ready_q, set_ready_q, error_q;

    logic        accept, is_digit, is_field, is_gm, is_lf;
    logic        term, proc_word, err, clear_line;
    logic [17:0] acc_next;
    field_e      letter_field;

    assign accept   = char_valid && ready_q;
    assign is_digit = (char_in >= ChZero) && (char_in <= ChNine);
    assign is_lf    = (char_in == ChLf);
    assign is_gm    = is_field && ((letter_field == FldG) || (letter_field == FldM));
    assign acc_next = ({4'd0, acc_q} * 18'd10) + {14'd0, char_in[3:0]};

    always_comb begin
        is_field     = 1'b0;
        letter_field = FldG;
        case (char_in)
            ChG: begin is_field = 1'b1; letter_field = FldG; end
            ChM: begin is_field = 1'b1; letter_field = FldM; end
            ChX: begin is_field = 1'b1; letter_field = FldX; end
            ChY: begin is_field = 1'b1; letter_field = FldY; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        field_d    = field_q;
        acc_d      = acc_q;
        digit_d    = digit_q;
        gm_d       = gm_q;
        is_m_d     = is_m_q;
        code_d     = code_q;
        x_seen_d   = x_seen_q;
        x_line_d   = x_line_q;
        y_seen_d   = y_seen_q;
        y_line_d   = y_line_q;
        cmd_d      = cmd_q;
        x_d        = x_q;
        y_d        = y_q;
        term       = 1'b0;
        proc_word  = 1'b0;
        err        = 1'b0;
        clear_line = 1'b0;

        unique case (state_q)
            StWord: proc_word = accept;
            StNum: begin
                if (accept) begin
                    if (is_digit) begin
                        acc_d   = (acc_next > {4'd0, AccMax}) ? AccMax : acc_next[13:0];
                        digit_d = 1'b1;
                    end else if (char_in == ChSp) begin
                        term = 1'b1;
                    end else if (is_lf || is_field || (CommentEn && char_in == ChSemi)) begin
                        // The terminating character is also handled as a word-level character.
                        term      = 1'b1;
                        proc_word = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            StSkip: if (accept && is_lf) state_d = StWord;
            StIssue: if (controller_ready) state_d = StWord;
            StComment: proc_word = accept && is_lf;
            StParen: begin
                if (accept) begin
                    if (is_lf) proc_word = 1'b1;
                    else if (char_in == ChRpar) state_d = StWord;
                end
            end
            default: state_d = StWord;
        endcase

        if (term) begin
            state_d = StWord;
            if (!digit_q) begin
                err = 1'b1;
            end else begin
                unique case (field_q)
                    FldG, FldM: begin
                        if (acc_q > 14'd15) begin
                            err = 1'b1;
                        end else begin
                            gm_d   = 1'b1;
                            is_m_d = (field_q == FldM);
                            code_d = acc_q[3:0];
                        end
                    end
                    FldX: begin x_seen_d = 1'b1; x_line_d = acc_q; end
                    FldY: begin y_seen_d = 1'b1; y_line_d = acc_q; end
                    default: ;
                endcase
            end
        end

        if (proc_word && !err) begin
            if (is_field) begin
                if (is_gm && gm_d) begin
                    err = 1'b1;
                end else begin
                    field_d = letter_field;
                    acc_d   = '0;
                    digit_d = 1'b0;
                    state_d = StNum;
                end
            end else if (is_lf) begin
                clear_line = 1'b1;
                if (gm_d) begin
                    state_d = StIssue;
                    cmd_d   = {is_m_d, code_d};
                    if (x_seen_d) x_d = x_line_d;
                    if (y_seen_d) y_d = y_line_d;
                end else begin
                    state_d = StWord;
                end
            end else if (char_in == ChSp || char_in == ChCr) begin
                state_d = StWord;
            end else if (CommentEn && char_in == ChSemi) begin
                state_d = StComment;
            end else if (CommentEn && char_in == ChLpar) begin
                state_d = StParen;
            end else begin
                err = 1'b1;
            end
        end

        if (err) begin
            clear_line = 1'b1;
            // An error raised by the LF itself already ends the line.
            state_d    = is_lf ? StWord : StSkip;
        end

        if (clear_line) begin
            gm_d     = 1'b0;
            x_seen_d = 1'b0;
            y_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StWord;
            field_q     <= FldG;
            acc_q       <= '0;
            digit_q     <= 1'b0;
            gm_q        <= 1'b0;
            is_m_q      <= 1'b0;
            code_q      <= '0;
            x_seen_q    <= 1'b0;
            x_line_q    <= '0;
            y_seen_q    <= 1'b0;
            y_line_q    <= '0;
            cmd_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            ready_q     <= 1'b0;
            set_ready_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            acc_q       <= acc_d;
            digit_q     <= digit_d;
            gm_q        <= gm_d;
            is_m_q      <= is_m_d;
            code_q      <= code_d;
            x_seen_q    <= x_seen_d;
            x_line_q    <= x_line_d;
            y_seen_q    <= y_seen_d;
            y_line_q    <= y_line_d;
            cmd_q       <= cmd_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ready_q     <= (state_d != StIssue);
            set_ready_q <= (state_d == StIssue);
            error_q     <= err;
        end
    end

    assign char_ready  = ready_q;
    assign set_ready   = set_ready_q;
    assign parse_error = error_q;
    assign cmd         = cmd_q;
    assign x_value     = x_q;
    assign y_value     = y_q;

endmodule

// File: doc/gcode_parser.md
GCODE_PARSER -- requirements
Module: gcode_parser

Interface
REQ-001 clk  input  1  single system clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on posedge clk; low = reset.
REQ-003 char_in  input  8  ASCII character from the upstream byte source.
REQ-004 char_valid  input  1  char_in holds a valid character.
REQ-005 char_ready  output  1  parser can accept a character; transfer occurs when char_valid && char_ready.
REQ-006 set_ready  output  1  level request to the downstream controller: cmd/x_value/y_value are valid.
REQ-007 controller_ready  input  1  downstream acknowledge; the downstream latches its outputs in the cycle this is high.
REQ-008 cmd  output  5  {is_M, code[3:0]}: bit4 = 1 for an M word, 0 for a G word.
REQ-009 x_value  output  14  unsigned X coordinate, modal.
REQ-010 y_value  output  14  unsigned Y coordinate, modal.
REQ-011 parse_error  output  1  one-cycle pulse on a malformed line.

Function
REQ-012 States: WORD (await letter), NUM (accumulate digits), SKIP (discard to newline) and ISSUE (request outstanding).
REQ-013 char_ready SHALL be 1 in WORD, NUM and SKIP, and 0 in ISSUE.
REQ-014 WORD: 'G'/'M'/'X'/'Y' SHALL record the field, clear the accumulator and go to NUM.
- Space and CR (0x0D) are ignored.
- LF (0x0A) goes to ISSUE if a G/M word was seen this line; otherwise it stays in WORD with no output.
REQ-015 NUM: digit '0'-'9' SHALL update acc = acc*10 + digit, saturating at 16383.
REQ-016 NUM: space, LF or a field letter SHALL terminate the field.
- A terminated field with zero digits is an error.
- The letter or LF that terminates a field is also processed as in WORD in the same cycle.
REQ-017 G/M code >15, a second G/M word in one line, or X/Y before any digit SHALL be an error.
REQ-018 Any other character (including a digit in WORD) SHALL be an error.
REQ-019 On error: pulse parse_error for 1 cycle, enter SKIP, and discard the partial line; modal X/Y are not updated.
REQ-020 SKIP: LF returns to WORD; all other characters are discarded.
REQ-021 Parsed values SHALL be held in shadow registers.
- cmd/x_value/y_value update only on entry to ISSUE and stay constant while set_ready = 1.
REQ-022 Lines without X or Y SHALL keep the previous x_value/y_value (modal).
REQ-023 Latency: LF accepted in cycle N gives set_ready = 1 and the new outputs in cycle N+1.
REQ-024 ISSUE: set_ready SHALL stay 1 until controller_ready is sampled 1.
- The next cycle drops set_ready to 0 and returns to WORD.
- set_ready is therefore low for at least 1 cycle between commands.
REQ-025 controller_ready outside ISSUE SHALL be ignored.
REQ-026 Simultaneous char_valid and ISSUE: the character is not accepted (char_ready = 0) and is not lost upstream.

Reset
REQ-027 While reset = 0: state = WORD, set_ready = 0, parse_error = 0, char_ready = 0, cmd = 0, x_value = 0, y_value = 0; accumulator and line flags cleared.
REQ-028 Reset asserted mid-line or during ISSUE SHALL abandon the command; no set_ready pulse follows release.
REQ-029 char_ready SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-030 Macro GCODE_COMMENT_EN, when defined: ';' in WORD or NUM terminates any open field, and the remaining characters up to LF are ignored.
- At that LF the line issues normally if a G/M word was seen.
- '(' ... ')' inline comments are ignored in WORD.
REQ-031 Without GCODE_COMMENT_EN: ';', '(' and ')' are errors per REQ-018.

Verification
REQ-032 "G1 X100 Y200\n", controller_ready pulsed 2 cycles after set_ready -> cmd=0x01, x=100, y=200; set_ready high 3 cycles, char_ready low throughout.
REQ-033 Then "M5\n" -> cmd=0x15, x=100, y=200 (modal retained).
REQ-034 "G1 X99999\n" -> x_value=16383 (saturated), no error.
REQ-035 "G1 XZ5\n" then "G0 Y7\n" -> single parse_error pulse, no issue for line 1; line 2 gives cmd=0x00, y=7, x unchanged.
REQ-036 Reset asserted one cycle after set_ready rises -> set_ready=0 and all outputs 0 the next cycle; no reissue after release.
REQ-037 With GCODE_COMMENT_EN: "G2 X3 ;move\n" -> cmd=0x02, x=3. Without it: the same line gives parse_error and no issue.
